// File: rtl/td_defuzzy_seq.sv
// rtl/td_defuzzy_seq.sv - interval type-2 defuzzifier: 3-set accumulate + serial restoring divide
// Optional TD_DEFUZZY_ROUND_EN: round-half-up on the final quotient instead of floor.
module td_defuzzy_seq #(
  parameter logic [7:0] POS_1    = 8'd0,
  parameter logic [7:0] POS_2    = 8'd128,
  parameter logic [7:0] POS_3    = 8'd255,
  parameter logic [7:0] ZERO_OUT = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inicio,
  input  logic [7:0] FOU_1_UP,
  input  logic [7:0] FOU_2_UP,
  input  logic [7:0] FOU_3_UP,
  input  logic [7:0] FOU_1_LOW,
  input  logic [7:0] FOU_2_LOW,
  input  logic [7:0] FOU_3_LOW,
  output logic       ocupado,
  output logic       pronto,
  output logic       erro_div,
  output logic [7:0] saida
);

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_CHECK, S_DIV, S_RESULT, S_DONE} state_t;

  state_t      state;
  logic [8:0]  f1, f2, f3;
  logic [4:0]  cnt;
  logic [18:0] num;
  logic [10:0] den;
  logic [10:0] rem;

  logic [8:0]  f_sel;
  logic [7:0]  pos_sel;
  logic [16:0] prod;
  logic [11:0] rem_sh;
  logic [10:0] rem_sub;
  logic        ge;
  logic        round_up;
  logic [19:0] q_adj;
  logic [7:0]  q_sat;

  always_comb begin
    f_sel   = f1;
    pos_sel = POS_1;
    case (cnt[1:0])
      2'd1: begin f_sel = f2; pos_sel = POS_2; end
      2'd2: begin f_sel = f3; pos_sel = POS_3; end
      default: ;
    endcase
  end

  assign prod = {8'd0, f_sel} * {9'd0, pos_sel};

  // num doubles as the quotient shift register: dividend bits leave at the top, quotient bits enter at the bottom.
  assign rem_sh  = {rem, num[18]};
  assign ge      = (rem_sh >= {1'b0, den});
  assign rem_sub = rem_sh[10:0] - den;

`ifdef TD_DEFUZZY_ROUND_EN
  assign round_up = ({rem, 1'b0} >= {1'b0, den});
`else
  assign round_up = 1'b0;
`endif

  assign q_adj = {1'b0, num} + {19'd0, round_up};
  assign q_sat = (q_adj > 20'd255) ? 8'hff : q_adj[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      f1       <= '0;
      f2       <= '0;
      f3       <= '0;
      cnt      <= '0;
      num      <= '0;
      den      <= '0;
      rem      <= '0;
      ocupado  <= 1'b0;
      pronto   <= 1'b0;
      erro_div <= 1'b0;
      saida    <= '0;
    end else begin
      pronto <= 1'b0;
      case (state)
        S_IDLE: begin
          if (inicio) begin
            f1      <= {1'b0, FOU_1_UP} + {1'b0, FOU_1_LOW};
            f2      <= {1'b0, FOU_2_UP} + {1'b0, FOU_2_LOW};
            f3      <= {1'b0, FOU_3_UP} + {1'b0, FOU_3_LOW};
            num     <= '0;
            den     <= '0;
            rem     <= '0;
            cnt     <= '0;
            ocupado <= 1'b1;
            state   <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          num <= num + {2'd0, prod};
          den <= den + {2'd0, f_sel};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd2) begin
            cnt   <= '0;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          cnt   <= '0;
          state <= (den == '0) ? S_RESULT : S_DIV;
        end
        S_DIV: begin
          rem <= ge ? rem_sub : rem_sh[10:0];
          num <= {num[17:0], ge};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd18) state <= S_RESULT;
        end
        S_RESULT: begin
          pronto <= 1'b1;
          if (den == '0) begin
            saida    <= ZERO_OUT;
            erro_div <= 1'b1;
          end else begin
            saida    <= q_sat;
            erro_div <= 1'b0;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          ocupado <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          ocupado <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_td_defuzzy_seq.sv
// tb/tb_td_defuzzy_seq.sv - randomized and directed bench for td_defuzzy_seq with a cycle-level reference model
module tb_td_defuzzy_seq;

  localparam logic [7:0] P1 = 8'd0;
  localparam logic [7:0] P2 = 8'd128;
  localparam logic [7:0] P3 = 8'd255;
  localparam logic [7:0] ZO = 8'd0;
`ifdef TD_DEFUZZY_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       inicio;
  logic [7:0] u1, u2, u3, l1, l2, l3;
  logic       ocupado, pronto, erro_div;
  logic [7:0] saida;

  int total = 0;
  int bad   = 0;

  td_defuzzy_seq #(.POS_1(P1), .POS_2(P2), .POS_3(P3), .ZERO_OUT(ZO)) dut (
    .clk(clk), .rst(rst), .inicio(inicio),
    .FOU_1_UP(u1), .FOU_2_UP(u2), .FOU_3_UP(u3),
    .FOU_1_LOW(l1), .FOU_2_LOW(l2), .FOU_3_LOW(l3),
    .ocupado(ocupado), .pronto(pronto), .erro_div(erro_div), .saida(saida)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_calc(input logic [7:0] a1, a2, a3, b1, b2, b3,
                                     output logic [7:0] s, output logic e);
    int f1, f2, f3, num, den, q, r;
    f1  = int'(a1) + int'(b1);
    f2  = int'(a2) + int'(b2);
    f3  = int'(a3) + int'(b3);
    num = f1 * int'(P1) + f2 * int'(P2) + f3 * int'(P3);
    den = f1 + f2 + f3;
    if (den == 0) begin
      s = ZO;
      e = 1'b1;
    end else begin
      q = num / den;
      r = num % den;
      if (RND == 1 && 2 * r >= den) q++;
      if (q > 255) q = 255;
      s = q[7:0];
      e = 1'b0;
    end
  endfunction

  // Reference model: an accepted operation reports after 24 edges (5 when den==0) and frees IDLE one edge later.
  logic       m_busy = 1'b0, m_pronto = 1'b0, m_erro = 1'b0, p_erro;
  logic [7:0] m_saida = 8'd0, p_saida;
  int         m_age = 0, m_lat = 0;

  always begin
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0; m_pronto = 1'b0; m_erro = 1'b0; m_saida = 8'd0;
    end else if (m_busy) begin
      m_age++;
      m_pronto = (m_age == m_lat);
      if (m_pronto) begin
        m_saida = p_saida;
        m_erro  = p_erro;
      end
      if (m_age == m_lat + 1) m_busy = 1'b0;
    end else if (inicio) begin
      model_calc(u1, u2, u3, l1, l2, l3, p_saida, p_erro);
      m_lat    = p_erro ? 5 : 24;
      m_age    = 0;
      m_busy   = 1'b1;
      m_pronto = 1'b0;
    end else begin
      m_pronto = 1'b0;
    end
    #1;
    chk("cyc_ocupado", ocupado, m_busy);
    chk("cyc_pronto", pronto, m_pronto);
    chk("cyc_saida", saida, m_saida);
    chk("cyc_erro_div", erro_div, m_erro);
  end

  task automatic rand_inputs();
    u1 = (($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom));
    u2 = (($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom));
    u3 = (($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom));
    l1 = (($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom));
    l2 = (($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom));
    l3 = (($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom));
    if ($urandom_range(0, 7) == 0) begin
      u1 = 0; u2 = 0; u3 = 0; l1 = 0; l2 = 0; l3 = 0;
    end
  endtask

  task automatic run_op(input logic [7:0] a1, a2, a3, b1, b2, b3, input bit disturb,
                        output logic [7:0] s, output logic e, output int lat, output int npr);
    @(negedge clk);
    u1 = a1; u2 = a2; u3 = a3; l1 = b1; l2 = b2; l3 = b3;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    lat = -1; npr = 0; s = 8'd0; e = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (pronto) begin
        if (lat < 0) begin
          lat = c; s = saida; e = erro_div;
        end
        npr++;
      end
      if (disturb && c == 8) begin
        inicio = 1'b1;
        rand_inputs();
      end
      if (disturb && c == 14) inicio = 1'b0;
      if (!ocupado && lat >= 0) break;
      @(negedge clk);
    end
  endtask

  logic [7:0] s, ms;
  logic       e, me;
  int         lat, npr;

  initial begin
    rst = 1'b1; inicio = 1'b0;
    u1 = 0; u2 = 0; u3 = 0; l1 = 0; l2 = 0; l3 = 0;
    repeat (3) @(negedge clk);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_saida", saida, 0);
    chk("rst_erro", erro_div, 0);
    rst = 1'b0;

    model_calc(100, 100, 100, 100, 100, 100, ms, me);
    chk("model_all100", ms, 127 + RND);
    model_calc(0, 0, 255, 0, 0, 255, ms, me);
    chk("model_set3", ms, 255);
    model_calc(50, 10, 0, 50, 0, 0, ms, me);
    chk("model_small", ms, 11 + RND);
    model_calc(0, 0, 0, 0, 0, 0, ms, me);
    chk("model_zero_err", me, 1);

    run_op(100, 100, 100, 100, 100, 100, 0, s, e, lat, npr);
    chk("all100_saida", s, 127 + RND);
    chk("all100_erro", e, 0);
    chk("all100_latency", lat, 24);

    run_op(0, 0, 255, 0, 0, 255, 0, s, e, lat, npr);
    chk("set3_saida", s, 255);
    chk("set3_erro", e, 0);

    run_op(0, 0, 0, 0, 0, 0, 0, s, e, lat, npr);
    chk("zero_saida", s, 0);
    chk("zero_erro", e, 1);
    chk("zero_latency", lat, 5);

    run_op(100, 100, 100, 100, 100, 100, 0, s, e, lat, npr);
    chk("after_zero_erro", e, 0);

    run_op(50, 10, 0, 50, 0, 0, 0, s, e, lat, npr);
    chk("small_saida", s, 11 + RND);

    run_op(100, 100, 100, 100, 100, 100, 1, s, e, lat, npr);
    chk("disturb_saida", s, 127 + RND);
    chk("disturb_pronto_count", npr, 1);

    @(negedge clk);
    u1 = 100; u2 = 100; u3 = 100; l1 = 100; l2 = 100; l3 = 100;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ocupado", ocupado, 0);
    chk("midrst_pronto", pronto, 0);
    chk("midrst_saida", saida, 0);
    chk("midrst_erro", erro_div, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(100, 100, 100, 100, 100, 100, 0, s, e, lat, npr);
    chk("postrst_saida", s, 127 + RND);
    chk("postrst_latency", lat, 24);

    for (int i = 0; i < 20; i++) begin
      rand_inputs();
      run_op(u1, u2, u3, l1, l2, l3, bit'($urandom_range(0, 1)), s, e, lat, npr);
      chk("rand_pronto_count", npr, 1);
    end

    @(negedge clk);
    inicio = 1'b1;
    for (int i = 0; i < 130; i++) begin
      rand_inputs();
      @(negedge clk);
    end
    inicio = 1'b0;
    repeat (30) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
